// File: rtl/pc_plus4_pkg.sv
// -----------------------------------------------------------------------------
// pc_plus4_pkg
// Shared constants for sequential-address generation. Reused by the fetch and
// branch units so that every PC+increment in the core agrees on width and step.
//   XLEN_DEFAULT : default program-counter width in bits
//   PC_INC       : sequential instruction step in bytes
// -----------------------------------------------------------------------------
package pc_plus4_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int PC_INC       = 4;

endpackage : pc_plus4_pkg

// File: rtl/pc_plus4_unit.sv
// -----------------------------------------------------------------------------
// pc_plus4_unit
// Sequential-address generator for the fetch path. Produces pc + INC with zero
// latency for the next-PC select mux, plus a registered copy with wrap and
// alignment status for pipeline and debug consumers.
//
// Ports:
//   clk          in   rising-edge clock for the registered outputs
//   rst          in   synchronous, active-high reset (registered outputs only)
//   pc           in   current program counter
//   pc_valid     in   qualifies pc for the registered stage
//   pc_plus4     out  combinational pc + INC, modulo 2^XLEN
//   wrap         out  combinational carry-out of pc + INC
//   misaligned   out  combinational, set when pc[1:0] != 0
//   pc_q         out  registered pc
//   pc_plus4_q   out  registered pc_plus4
//   wrap_q       out  registered wrap
//   misaligned_q out  registered misaligned
//   valid_q      out  registered pc_valid
// -----------------------------------------------------------------------------
module pc_plus4_unit
   import pc_plus4_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int INC  = PC_INC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            pc_valid,
   output logic [XLEN-1:0] pc_plus4,
   output logic            wrap,
   output logic            misaligned,
   output logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] pc_plus4_q,
   output logic            wrap_q,
   output logic            misaligned_q,
   output logic            valid_q
);

   // One extra bit on the sum captures the carry-out that becomes wrap.
   logic [XLEN:0] sum_full;

   assign sum_full   = {1'b0, pc} + (XLEN+1)'(INC);
   assign pc_plus4   = sum_full[XLEN-1:0];
   assign wrap       = sum_full[XLEN];
   // Flag only: a misaligned pc is still incremented normally.
   assign misaligned = |pc[1:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= '0;
         pc_plus4_q   <= '0;
         wrap_q       <= 1'b0;
         misaligned_q <= 1'b0;
         valid_q      <= 1'b0;
      end else if (pc_valid) begin
         pc_q         <= pc;
         pc_plus4_q   <= pc_plus4;
         wrap_q       <= wrap;
         misaligned_q <= misaligned;
         valid_q      <= 1'b1;
      end else begin
         // Data registers hold their last captured values; only valid drops.
         valid_q      <= 1'b0;
      end
   end

endmodule : pc_plus4_unit

// File: tb/tb_pc_plus4_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_plus4_unit
// Self-checking bench for pc_plus4_unit: hand-computed literal checks plus a
// behavioural model compared against the DUT on every falling clock edge
// during randomized stimulus.
// -----------------------------------------------------------------------------
module tb_pc_plus4_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            clk_run = 1'b0;
   logic            rst = 1'b0;
   logic [XLEN-1:0] pc = '0;
   logic            pc_valid = 1'b0;
   logic [XLEN-1:0] pc_plus4;
   logic            wrap;
   logic            misaligned;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4_q;
   logic            wrap_q;
   logic            misaligned_q;
   logic            valid_q;

   int checks = 0;
   int errors = 0;

   pc_plus4_unit #(.XLEN(XLEN), .INC(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .pc_plus4     (pc_plus4),
      .wrap         (wrap),
      .misaligned   (misaligned),
      .pc_q         (pc_q),
      .pc_plus4_q   (pc_plus4_q),
      .wrap_q       (wrap_q),
      .misaligned_q (misaligned_q),
      .valid_q      (valid_q)
   );

   initial begin
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] actual,
                        input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Combinational expectations from plain 64-bit arithmetic.
   function automatic logic [63:0] model_sum(input logic [XLEN-1:0] p);
      return {32'b0, p} + 64'd4;
   endfunction

   // Registered expectations: what the registered outputs must show after an edge.
   logic            m_known = 1'b0;
   logic [XLEN-1:0] m_pc_q, m_pc_plus4_q;
   logic            m_wrap_q, m_mis_q, m_valid_q;

   always @(posedge clk) begin
      logic [63:0] s;
      s = model_sum(pc);
      if (rst) begin
         m_known      = 1'b1;
         m_pc_q       = '0;
         m_pc_plus4_q = '0;
         m_wrap_q     = 1'b0;
         m_mis_q      = 1'b0;
         m_valid_q    = 1'b0;
      end else if (pc_valid) begin
         m_pc_q       = pc;
         m_pc_plus4_q = s[31:0];
         m_wrap_q     = s[32];
         m_mis_q      = (pc % 4) != 0;
         m_valid_q    = 1'b1;
      end else begin
         m_valid_q    = 1'b0;
      end
   end

   // ---------------- compare process ----------------
   logic cmp_en = 1'b0;

   always @(negedge clk) begin
      logic [63:0] s;
      if (cmp_en) begin
         s = model_sum(pc);
         check("pc_plus4", {32'b0, pc_plus4}, {32'b0, s[31:0]});
         check("wrap", {63'b0, wrap}, {63'b0, s[32]});
         check("misaligned", {63'b0, misaligned}, {63'b0, (pc % 4) != 0});
         if (m_known) begin
            check("valid_q", {63'b0, valid_q}, {63'b0, m_valid_q});
            check("pc_q", {32'b0, pc_q}, {32'b0, m_pc_q});
            check("pc_plus4_q", {32'b0, pc_plus4_q}, {32'b0, m_pc_plus4_q});
            check("wrap_q", {63'b0, wrap_q}, {63'b0, m_wrap_q});
            check("misaligned_q", {63'b0, misaligned_q}, {63'b0, m_mis_q});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic comb_literal(input logic [31:0] p, input logic [31:0] exp_sum,
                               input logic exp_wrap, input logic exp_mis);
      pc = p;
      #1;
      check("lit_pc_plus4", {32'b0, pc_plus4}, {32'b0, exp_sum});
      check("lit_wrap", {63'b0, wrap}, {63'b0, exp_wrap});
      check("lit_misaligned", {63'b0, misaligned}, {63'b0, exp_mis});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Combinational path with no clock running.
      pc = 32'h0000_0000;
      #10;
      check("noclk_pc_plus4", {32'b0, pc_plus4}, 64'h4);
      check("noclk_wrap", {63'b0, wrap}, 64'h0);
      check("noclk_misaligned", {63'b0, misaligned}, 64'h0);
      comb_literal(32'h0000_0010, 32'h0000_0014, 1'b0, 1'b0);
      comb_literal(32'h0000_7709, 32'h0000_770D, 1'b0, 1'b1);
      comb_literal(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0);
      comb_literal(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, 1'b1);
      comb_literal(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b1);

      // Reset held two cycles with valid input present.
      rst = 1'b1; pc_valid = 1'b1; pc = 32'h100;
      clk_run = 1'b1;
      cmp_en  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_valid_q", {63'b0, valid_q}, 64'h0);
         check("rst_pc_q", {32'b0, pc_q}, 64'h0);
         check("rst_pc_plus4_q", {32'b0, pc_plus4_q}, 64'h0);
         check("rst_live_pc_plus4", {32'b0, pc_plus4}, 64'h104);
      end
      rst = 1'b0;
      step();
      check("first_pc_q", {32'b0, pc_q}, 64'h100);
      check("first_pc_plus4_q", {32'b0, pc_plus4_q}, 64'h104);
      check("first_valid_q", {63'b0, valid_q}, 64'h1);

      // Hold behaviour when pc_valid drops.
      pc = 32'h20; pc_valid = 1'b1;
      step();
      pc = 32'h40; pc_valid = 1'b0;
      step();
      check("hold_valid_q", {63'b0, valid_q}, 64'h0);
      check("hold_pc_plus4_q", {32'b0, pc_plus4_q}, 64'h24);
      check("hold_pc_q", {32'b0, pc_q}, 64'h20);
      check("hold_live_pc_plus4", {32'b0, pc_plus4}, 64'h44);

      // Randomized stream with boundary values mixed in.
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 9))
            0:       pc = 32'hFFFF_FFFC - 32'($urandom_range(0, 4));
            1:       pc = 32'($urandom_range(0, 7));
            default: pc = $urandom;
         endcase
         pc_valid = ($urandom_range(0, 3) != 0);
         rst      = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;
      step();
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got t=%0t expected < 200000", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pc_plus4_unit
